trng_conditioner: RTL

Conditioning stage directly downstream of the ring-oscillator entropy source. It synchronises the free-running raw bit into the system clock domain and samples it at a programmable rate. It runs a repetition-count health test, removes bias with a von Neumann extractor and assembles whole bytes. Bytes leave through a valid/ready handshake toward the pin-level output logic of the top module.

---
 rtl/trng_conditioner_if.sv | 19 +
 rtl/trng_conditioner.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/trng_conditioner_if.sv
// rtl/trng_conditioner_if.sv - byte output handshake between the conditioner and its consumer

interface trng_conditioner_if;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_out,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_out,
    input  byte_valid,
    output byte_ready
  );
endinterface

// File: rtl/trng_conditioner.sv
// rtl/trng_conditioner.sv - ring-oscillator bit conditioning: sync, rate divider,
// repetition-count health test, von Neumann extractor and byte assembler

module trng_conditioner #(
  parameter int DIV       = 4,
  parameter int REP_LIMIT = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                raw_in,
  trng_conditioner_if.master  out_if,
  output logic                health_fail,
  output logic                ovf
);

  localparam int              DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(DIV - 1);
  localparam logic [7:0]      REP_MAX  = 8'(REP_LIMIT);

  typedef enum logic {PH0, PH1} phase_t;

  logic          s1, s2;
  logic [DW-1:0] div_cnt;
  logic          strobe;
  logic          first_sample;
  logic          last;
  logic [7:0]    rep_cnt, rep_next;
  logic          hf_trip;
  phase_t        phase, phase_next;
  logic          first_bit;
  logic          emit;
  logic [6:0]    sh;
  logic [2:0]    bit_cnt;
  logic          byte_done, handoff, load;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw_in;
      s2 <= s1;
    end
  end

  assign strobe = en && (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || !en || strobe) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Repetition count evaluated combinationally so the trip can gate emission on the same strobe
  always_comb begin
    rep_next = rep_cnt;
    hf_trip  = 1'b0;
    if (strobe) begin
      if (first_sample) begin
        rep_next = 8'd1;
      end else if (s2 == last) begin
        rep_next = (rep_cnt >= REP_MAX) ? REP_MAX : rep_cnt + 8'd1;
      end else begin
        rep_next = 8'd1;
      end
      hf_trip = (rep_next == REP_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first_sample <= 1'b1;
      last         <= 1'b0;
      rep_cnt      <= 8'd0;
      health_fail  <= 1'b0;
    end else begin
      rep_cnt     <= rep_next;
      health_fail <= health_fail | hf_trip;
      if (strobe) begin
        first_sample <= 1'b0;
        last         <= s2;
      end
    end
  end

  always_comb begin
    phase_next = phase;
    emit       = 1'b0;
    if (!en) begin
      phase_next = PH0;
    end else if (strobe) begin
      case (phase)
        PH0: phase_next = PH1;
        PH1: begin
          phase_next = PH0;
          emit       = (first_bit != s2) && !health_fail && !hf_trip;
        end
        default: phase_next = PH0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase     <= PH0;
      first_bit <= 1'b0;
    end else begin
      phase <= phase_next;
      if (strobe && phase == PH0) begin
        first_bit <= s2;
      end
    end
  end

  assign byte_done = emit && (bit_cnt == 3'd7);
  assign handoff   = out_if.byte_valid && out_if.byte_ready;
  // A handoff on this edge frees the slot, so a completing byte may load back-to-back
  assign load      = byte_done && (!out_if.byte_valid || out_if.byte_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh                <= 7'd0;
      bit_cnt           <= 3'd0;
      ovf               <= 1'b0;
      out_if.byte_out   <= 8'h00;
      out_if.byte_valid <= 1'b0;
    end else begin
      if (emit) begin
        sh      <= {sh[5:0], first_bit};
        bit_cnt <= bit_cnt + 3'd1;
      end
      ovf <= byte_done && !load;
      if (load) begin
        out_if.byte_out   <= {sh, first_bit};
        out_if.byte_valid <= 1'b1;
      end else if (handoff) begin
        out_if.byte_valid <= 1'b0;
      end
    end
  end

endmodule
